// File: rtl/axi_lite_tohost.sv
// axi_lite_tohost: AXI-Lite test-status slave. The test program stores a
// completion code to TOHOST; the block latches done/pass/fail_code, runs a
// cycle counter that freezes on completion and flags a sticky timeout.
module axi_lite_tohost #(
   parameter logic [31:0] BASE    = 32'h0000_2000,
   parameter logic [31:0] TIMEOUT = 32'd3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        done,
   output logic        pass,
   output logic [30:0] fail_code,
   output logic        timeout
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

   // Apply byte enables of a write onto the current register value.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
         else         res[i*8 +: 8] = old_v[i*8 +: 8];
      end
      return res;
   endfunction

   wr_state_t   wstate_r, wstate_s;
   rd_state_t   rstate_r, rstate_s;
   logic        aw_cap_r, w_cap_r;
   logic [31:0] awaddr_r, wdata_r;
   logic [3:0]  wstrb_r;
   logic [31:0] tohost_r, cycles_r;
   logic        done_r, pass_r, timeout_r;
   logic [30:0] fail_code_r;
   logic        bvalid_r, rvalid_r;
   logic [1:0]  bresp_r, rresp_r;
   logic [31:0] rdata_r;

   logic        aw_hs_s, w_hs_s, wr_fire_s, wr_in_s, wr_tohost_s, ar_hs_s, rd_in_s;
   logic [31:0] wr_addr_s, wr_data_s, wr_off_s, merged_s, rd_off_s, rd_data_s, status_s;
   logic [3:0]  wr_strb_s;
   logic [1:0]  rd_resp_s;

   // Ready signals decode straight from FSM state so they read 1 in reset.
   assign awready   = (wstate_r == W_IDLE) && !aw_cap_r;
   assign wready    = (wstate_r == W_IDLE) && !w_cap_r;
   assign arready   = (rstate_r == R_IDLE);
   assign aw_hs_s   = awvalid && awready;
   assign w_hs_s    = wvalid && wready;
   assign ar_hs_s   = arvalid && arready;

   // A write fires on the edge where the later of AW/W is accepted, using
   // the captured half and the live bus half together.
   assign wr_addr_s   = aw_cap_r ? awaddr_r : awaddr;
   assign wr_data_s   = w_cap_r ? wdata_r : wdata;
   assign wr_strb_s   = w_cap_r ? wstrb_r : wstrb;
   assign wr_fire_s   = (wstate_r == W_IDLE) && (aw_cap_r || aw_hs_s) && (w_cap_r || w_hs_s);
   assign wr_off_s    = wr_addr_s - BASE;
   assign wr_in_s     = (wr_off_s < 32'd16);
   assign wr_tohost_s = wr_in_s && (wr_off_s[3:2] == 2'b00);
   assign merged_s    = byte_merge(tohost_r, wr_data_s, wr_strb_s);

   assign rd_off_s  = araddr - BASE;
   assign rd_in_s   = (rd_off_s < 32'd16);
   assign status_s  = {28'd0, timeout_r, pass_r, done_r, 1'b0};

   assign bvalid    = bvalid_r;
   assign bresp     = bresp_r;
   assign rvalid    = rvalid_r;
   assign rdata     = rdata_r;
   assign rresp     = rresp_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail_code = fail_code_r;
   assign timeout   = timeout_r;

   // State registers for both independent FSMs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_r <= W_IDLE;
         rstate_r <= R_IDLE;
      end else begin
         wstate_r <= wstate_s;
         rstate_r <= rstate_s;
      end
   end

   // Write FSM next state: respond once both halves are in, wait for bready.
   always_comb begin
      wstate_s = wstate_r;
      case (wstate_r)
         W_IDLE:  if (wr_fire_s) wstate_s = W_RESP; else wstate_s = W_IDLE;
         W_RESP:  if (bready)    wstate_s = W_IDLE; else wstate_s = W_RESP;
         default: wstate_s = W_IDLE;
      endcase
   end

   // Read FSM next state: accept an address, then hold data until rready.
   always_comb begin
      rstate_s = rstate_r;
      case (rstate_r)
         R_IDLE:  if (ar_hs_s) rstate_s = R_DATA; else rstate_s = R_IDLE;
         R_DATA:  if (rready)  rstate_s = R_IDLE; else rstate_s = R_DATA;
         default: rstate_s = R_IDLE;
      endcase
   end

   // Read mux over register values as they stand before the current edge.
   always_comb begin
      rd_data_s = 32'd0;
      rd_resp_s = RESP_OKAY;
      if (rd_in_s) begin
         case (rd_off_s[3:2])
            2'b00:   rd_data_s = tohost_r;
            2'b01:   rd_data_s = cycles_r;
            2'b10:   rd_data_s = status_s;
            default: rd_data_s = 32'd0;
         endcase
      end else begin
         rd_resp_s = RESP_SLVERR;
      end
   end

   // Capture whichever of AW/W arrives first; drop captures when the write fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_cap_r <= 1'b0;
         w_cap_r  <= 1'b0;
         awaddr_r <= 32'd0;
         wdata_r  <= 32'd0;
         wstrb_r  <= 4'd0;
      end else if (wr_fire_s) begin
         aw_cap_r <= 1'b0;
         w_cap_r  <= 1'b0;
      end else begin
         if (aw_hs_s) begin
            aw_cap_r <= 1'b1;
            awaddr_r <= awaddr;
         end
         if (w_hs_s) begin
            w_cap_r <= 1'b1;
            wdata_r <= wdata;
            wstrb_r <= wstrb;
         end
      end
   end

   // Write response channel: only TOHOST is writable, everything else errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bvalid_r <= 1'b0;
         bresp_r  <= RESP_OKAY;
      end else if (wr_fire_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= wr_tohost_s ? RESP_OKAY : RESP_SLVERR;
      end else if ((wstate_r == W_RESP) && bready) begin
         bvalid_r <= 1'b0;
      end
   end

   // TOHOST and completion latch; once done, later writes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tohost_r    <= 32'd0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_code_r <= 31'd0;
      end else if (wr_fire_s && wr_tohost_s && !done_r) begin
         tohost_r <= merged_s;
         if (merged_s[0]) begin
            done_r      <= 1'b1;
            fail_code_r <= merged_s[31:1];
            pass_r      <= (merged_s[31:1] == 31'd0);
         end
      end
   end

   // Cycle counter freezes at completion; timeout is sticky.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycles_r  <= 32'd0;
         timeout_r <= 1'b0;
      end else if (!done_r) begin
         cycles_r <= cycles_r + 32'd1;
         if (cycles_r == TIMEOUT - 32'd1) timeout_r <= 1'b1;
      end
   end

   // Read data channel: sample on AR handshake, hold until rready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'd0;
         rresp_r  <= RESP_OKAY;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= rd_data_s;
         rresp_r  <= rd_resp_s;
      end else if ((rstate_r == R_DATA) && rready) begin
         rvalid_r <= 1'b0;
      end
   end

endmodule
